// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding,
// parity mode codes and oversampling constants.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Mode 2'b11 is treated like PARITY_NONE: no parity bit on the wire.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. Head word is visible on
// rd_data_o whenever the FIFO is non-empty and reads as zero when empty.
// Push and pop in the same cycle are both honoured, including when full.
//
// Ports:
//   clk_in     in   clock
//   sys_rstn   in   async active-low reset, empties the FIFO
//   push_i     in   write wr_data_i (ignored when full unless popping)
//   wr_data_i  in   write data
//   pop_i      in   drop head word (ignored when empty)
//   rd_data_o  out  head word, 0 when empty
//   count_o    out  occupancy 0..DEPTH
//   full_o     out  count == DEPTH
//   empty_o    out  count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_in,
    input  logic             sys_rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 16x oversampling UART receiver with runtime baud divisor and parity mode,
// feeding a FWFT receive FIFO. Errors are sticky until err_clr; irq follows
// the FIFO fill level one cycle late.
//
// Ports:
//   clk_in       in   system clock
//   sys_rstn     in   async active-low reset
//   uart_rxd     in   asynchronous serial line, idles high
//   baud_div     in   tick period = baud_div+1 clocks, 16 ticks per bit
//   parity_mode  in   00/11 none, 01 odd, 10 even
//   rd_en        in   pop FIFO head
//   err_clr      in   clear sticky error flags
//   rd_data      out  FIFO head, 0 when empty
//   rd_valid     out  FIFO not empty
//   count        out  FIFO occupancy
//   frame_err    out  sticky, stop bit sampled low
//   parity_err   out  sticky, parity mismatch
//   overrun_err  out  sticky, byte arrived while FIFO full
//   irq          out  registered, count >= IRQ_LEVEL
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a synchronised falling edge
// ST_START  | qualifying the start bit at its mid-point
// ST_DATA   | sampling 8 data bits LSB first, one per 16 ticks
// ST_PARITY | sampling the parity bit and checking it against the data
// ST_STOP   | sampling the stop bit, then pushing or flagging the byte
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DIV_WIDTH = 16,
    parameter  int DEPTH     = 8,
    parameter  int IRQ_LEVEL = 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk_in,
    input  logic                 sys_rstn,
    input  logic                 uart_rxd,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic [CW-1:0]        count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 irq
);

    localparam logic [3:0] OS_MID  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

    logic                 sync1_q, sync2_q, hist_q;
    logic                 rx_s;
    logic                 start_edge;

    logic [DIV_WIDTH-1:0] tick_cnt_q;
    logic [DIV_WIDTH-1:0] baud_div_q;
    logic                 tick;

    rx_state_e            state_q;
    logic [3:0]           os_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 bad_q;
    logic [1:0]           par_q;
    logic                 frame_err_q, parity_err_q, overrun_err_q;
    logic                 irq_q;

    logic                 stop_sample;
    logic                 frame_set, parity_set, overrun_set, push;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;

    // Input synchroniser plus history flop for falling-edge detection.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rx_s       = sync2_q;
    assign start_edge = (state_q == ST_IDLE) && hist_q && !rx_s;

    // Oversample tick generator; restarted on the start edge so that the
    // tick phase is aligned to the start bit.
    assign tick = (tick_cnt_q == baud_div_q);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tick_cnt_q <= '0;
        end else if (start_edge || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + DIV_WIDTH'(1);
        end
    end

    // Stop-bit outcome, in priority order: framing, parity, overrun, push.
    assign stop_sample = (state_q == ST_STOP) && tick && (os_cnt_q == OS_LAST);
    assign frame_set   = stop_sample && !rx_s;
    assign parity_set  = stop_sample && rx_s && bad_q;
    assign overrun_set = stop_sample && rx_s && !bad_q && fifo_full && !rd_en;
    assign push        = stop_sample && rx_s && !bad_q && (!fifo_full || rd_en);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q       <= ST_IDLE;
            os_cnt_q      <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            bad_q         <= 1'b0;
            baud_div_q    <= '0;
            par_q         <= PARITY_NONE;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            if (err_clr) begin
                frame_err_q   <= 1'b0;
                parity_err_q  <= 1'b0;
                overrun_err_q <= 1'b0;
            end
            // Later assignment wins: a new error beats a same-cycle clear.
            if (frame_set)   frame_err_q   <= 1'b1;
            if (parity_set)  parity_err_q  <= 1'b1;
            if (overrun_set) overrun_err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q    <= ST_START;
                        os_cnt_q   <= '0;
                        bad_q      <= 1'b0;
                        baud_div_q <= baud_div;
                        par_q      <= parity_mode;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (os_cnt_q == OS_MID) begin
                            os_cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q   <= ST_DATA;
                                bit_idx_q <= '0;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        os_cnt_q <= os_cnt_q + 4'd1;
                        if (os_cnt_q == OS_LAST) begin
                            shift_q   <= {rx_s, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= parity_enabled(par_q) ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        os_cnt_q <= os_cnt_q + 4'd1;
                        if (os_cnt_q == OS_LAST) begin
                            // Odd wants total XOR = 1, even wants 0.
                            bad_q   <= (^shift_q) ^ rx_s ^ (par_q == PARITY_ODD);
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        os_cnt_q <= os_cnt_q + 4'd1;
                        // Leave at mid-stop so a back-to-back start edge is seen.
                        if (os_cnt_q == OS_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_in    (clk_in),
        .sys_rstn  (sys_rstn),
        .push_i    (push),
        .wr_data_i (shift_q),
        .pop_i     (rd_en),
        .rd_data_o (rd_data),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (fifo_count >= CW'(IRQ_LEVEL));
        end
    end

    assign rd_valid    = !fifo_empty;
    assign count       = fifo_count;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
    assign irq         = irq_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised board-level UART receiver for the MIPS SoC bridge, driven by the board pin uart_rxd.
- Provides 16x oversampling, a runtime baud divisor, runtime parity mode, and a configurable-depth receive FIFO.
- Errors are reported through sticky flags; irq asserts when the FIFO reaches a fill threshold.
- Sits between the uart_rxd pin and the CPU's memory-mapped peripheral bus.

Parameters:
- DIV_WIDTH, 16: width of baud_div.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- IRQ_LEVEL, 1: irq asserts when count >= IRQ_LEVEL; range 1..DEPTH.

Ports:
- clk_in  in  1  system clock, single domain.
- sys_rstn  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial line; asynchronous; idles high.
- baud_div  in  DIV_WIDTH  oversample tick period = baud_div+1 clocks; one bit = 16 ticks.
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 none.
- rd_en  in  1  pop FIFO head.
- err_clr  in  1  clear all sticky error flags.
- rd_data  out  8  FIFO head, first-word-fall-through; 0 when empty.
- rd_valid  out  1  FIFO not empty.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- frame_err  out  1  sticky; stop bit sampled low.
- parity_err  out  1  sticky; parity mismatch.
- overrun_err  out  1  sticky; byte arrived while FIFO full.
- irq  out  1  registered; count >= IRQ_LEVEL.

Behaviour:
- Reset (async, sys_rstn=0):
  - synchroniser flops = 1; FSM = IDLE; tick counter = 0.
  - FIFO empty: count = 0, rd_valid = 0, rd_data = 0.
  - all error flags = 0; irq = 0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Input path:
  - 2-flop synchroniser on uart_rxd, plus one history flop for falling-edge detection.
- Tick generator:
  - Free-running counter reloads at baud_div_q; emits a 1-cycle tick.
  - Restarts from 0 on start-edge detection so bit phase is aligned.
- Configuration latch:
  - baud_div and parity_mode are captured into baud_div_q and par_q on start-edge detection.
  - Changes mid-frame have no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised falling edge.
  - START: at tick 8 (mid-bit), if line = 1 it is a false start -> IDLE; else -> DATA with bit index 0.
  - DATA: sample every 16 ticks, LSB first, into a shift register. After bit 7, go to PARITY if par_q is odd/even, else STOP.
  - PARITY: sample at mid-bit. Odd mode requires the XOR of data and parity bit = 1; even mode requires it = 0. Mismatch latches an internal bad flag -> STOP.
  - STOP: sample at mid-bit, then -> IDLE on the same tick. There is no wait for the end of the stop bit, so a back-to-back start edge is caught.
- Stop-sample outcomes, checked in this order:
  - line = 0: set frame_err, drop byte.
  - parity bad: set parity_err, drop byte.
  - FIFO full and no rd_en this cycle: set overrun_err, drop byte; existing contents are untouched.
  - otherwise: push the byte.
- Latency:
  - A pushed byte appears on rd_data/rd_valid the cycle after the stop mid-sample tick.
  - irq updates one cycle after count.
- FIFO rules:
  - rd_en while empty: ignored.
  - push + pop in the same cycle: both occur, count unchanged; also legal when full (no overrun).
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Error flags:
  - err_clr clears all three flags.
  - An error set and err_clr in the same cycle: set wins.
- False start and frame/parity errors never change count.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants.
  - PARITY_NONE/ODD/EVEN codes.
  - OVERSAMPLE = 16 and MID_SAMPLE = 8.
- One natural sub-module: sync_fifo, parametrised by DEPTH and width 8. It provides FWFT read, simultaneous push/pop, and full/empty/count outputs.
- Synchroniser, tick generator and FSM live in uart_rx_fifo.

Test Plan:
- baud_div=0, parity none, send 0xA5 (16 clk/bit) -> 1 cycle after stop mid-sample: rd_valid=1, rd_data=0xA5, count=1, no errors; rd_en pulse -> count=0, rd_data=0.
- baud_div=3, parity even, send 0x3C with parity 0 -> accepted. Then send 0x3C with parity 1 -> parity_err=1, count stays 1. Then err_clr -> parity_err=0.
- DEPTH=8: send 9 bytes 0x01..0x09 without reads -> count=8, overrun_err=1, head=0x01. Repeat with rd_en asserted on the 9th stop tick -> no overrun, count=8, head=0x02.
- Stop bit driven low on 0x55 -> frame_err=1, count unchanged. A 4-tick low glitch on an idle line -> false start, FSM returns to IDLE, no flags set.
- IRQ_LEVEL=4: after the 4th byte -> irq=1 one cycle later; one pop -> irq=0. Assert sys_rstn=0 mid-DATA of a 5th byte -> all outputs at reset values immediately.
- Change baud_div from 0 to 7 mid-frame -> the current byte is still received correctly at the old rate; the next frame uses 128 clk/bit.
